// File: rtl/mem_bus_arbiter.sv
// Shared memory bus arbiter for the fetch and MEM-stage data ports.
// Data accesses win over fetches; results are held until consumed.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              if_ce,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_stallreq,
    input  logic              d_ce,
    input  logic              d_we,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stallreq,
    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t state;
    logic   i_valid;
    logic   d_valid;
    logic   discard;

    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

    assign if_stallreq = if_ce & ~i_valid;
    assign d_stallreq  = d_ce & ~d_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            i_valid   <= 1'b0;
            d_valid   <= 1'b0;
            discard   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= 4'h0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_inst   <= '0;
            d_rdata   <= '0;
        end else begin
            if (i_valid && !stall[1]) begin
                i_valid <= 1'b0;
            end
            if (d_valid && !stall[4]) begin
                d_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (d_ce && !d_valid) begin
                        bus_req   <= 1'b1;
                        bus_we    <= d_we;
                        bus_sel   <= d_sel;
                        bus_addr  <= d_addr;
                        bus_wdata <= d_wdata;
                        state     <= BUSY_D;
                    end else if (if_ce && !i_valid) begin
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_sel  <= 4'hF;
                        bus_addr <= if_addr;
                        state    <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        bus_sel <= 4'h0;
                        state   <= IDLE;
                        discard <= 1'b0;
                        // a flush on the ack edge drops the word too
                        if (!discard && !flush) begin
                            if_inst <= bus_rdata;
                            i_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        bus_sel <= 4'h0;
                        state   <= IDLE;
                        d_valid <= 1'b1;
                        if (!bus_we) begin
                            d_rdata <= bus_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // flush overrides any set or clear of the valid flags
            if (flush) begin
                i_valid <= 1'b0;
                d_valid <= 1'b0;
            end
        end
    end

endmodule
